// File: rtl/spi_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_pkg
// Brief    : Shared constants, opcodes and state type for the SPI command
//            engine that sits under the QSPI memory controller.
// Revision : 1.0 - initial release
// ============================================================================
package spi_cmd_pkg;

   // Largest payload the caller may send after a 4-byte command/address head
   localparam int MAXCMD       = 256;
   localparam int c_DIN_BYTES  = 4 + MAXCMD;
   localparam int c_DIN_W      = c_DIN_BYTES * 8;
   localparam int c_DOUT_W     = 64;

   // Clocks spent per bit/nibble slot (SCK = clk/2) and in the closing state
   localparam int c_CLK_PER_SLOT = 2;
   localparam int c_END_CYCLES   = 2;

   // N25Q-style opcodes used by the controller above this block
   localparam logic [7:0] c_OP_RDID    = 8'h9F;
   localparam logic [7:0] c_OP_MIORDID = 8'hAF;
   localparam logic [7:0] c_OP_RDSR    = 8'h05;
   localparam logic [7:0] c_OP_RFSR    = 8'h70;
   localparam logic [7:0] c_OP_WREN    = 8'h06;
   localparam logic [7:0] c_OP_PP      = 8'h02;
   localparam logic [7:0] c_OP_SE      = 8'hD8;
   localparam logic [7:0] c_OP_BE      = 8'hC7;
   localparam logic [7:0] c_OP_READ    = 8'h03;
   localparam logic [7:0] c_OP_WRVECR  = 8'h61;
   localparam logic [7:0] c_OP_RDVECR  = 8'h65;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_RECV = 2'd2,
      ST_END  = 2'd3
   } state_t;

   // Transmit byte count can never exceed the width of the data_in bus
   function automatic logic [8:0] clamp_count(input logic [8:0] i_n);
      return (i_n > 9'(c_DIN_BYTES)) ? 9'(c_DIN_BYTES) : i_n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sck_out.sv
`default_nettype none
// ============================================================================
// Module   : spi_sck_out
// Brief    : Wrapper for the configuration-clock pin primitive that carries
//            SCK off chip. Behavioural stand-in: the internal sck net is the
//            value presented to the primitive and is probed in simulation.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sck_out (
   input  logic i_sck,
   output logic o_sck
);

   logic sck;

   assign sck   = i_sck;
   // Pin-side view of SCK, returned so the engine paces slots off the real clock
   assign o_sck = sck;

endmodule
`default_nettype wire

// File: rtl/spi_cmd.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd
// Brief    : Generic SPI / quad-SPI command engine. Asserts S, shifts out up
//            to 4+MAXCMD bytes (highest index first, MSB first), optionally
//            shifts in response bytes, then releases S.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd
   import spi_cmd_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                trigger,
   input  logic                quad,
   input  logic [8:0]          data_in_count,
   input  logic [7:0]          data_out_count,
   input  logic [c_DIN_W-1:0]  data_in,
   output logic [c_DOUT_W-1:0] data_out,
   output logic                busy,
   inout  wire  [3:0]          DQio,
   output logic                S
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_DIN_W-1:0]  r_data;
   logic                r_quad;
   logic [7:0]          r_m;
   logic [8:0]          r_cnt;      // bytes left in the current phase
   logic [2:0]          r_bit;      // bit (single) / nibble-top (quad) pointer
   logic                r_phase;    // 0 = SCK-low half, 1 = SCK-high half
   logic [c_DOUT_W-1:0] r_dout;

   logic                w_active;
   logic                w_sck_drive;
   logic                w_sck;
   logic                w_byte_done;
   logic                w_last_byte;
   logic [8:0]          w_n_clamp;
   logic [8:0]          w_idx;
   logic [7:0]          w_cur_byte;
   logic [3:0]          w_oe;
   logic [3:0]          w_dq;

   assign w_n_clamp   = clamp_count(data_in_count);
   assign w_active    = (r_state == ST_SEND) || (r_state == ST_RECV);
   assign w_sck_drive = w_active & r_phase;
   assign w_byte_done = r_quad ? ~r_bit[2] : (r_bit == 3'd0);
   assign w_last_byte = (r_cnt == 9'd1);
   assign w_idx       = (r_cnt == 9'd0) ? 9'd0 : r_cnt - 9'd1;
   assign w_cur_byte  = r_data[{w_idx, 3'b000} +: 8];

   spi_sck_out u_sck_out (
      .i_sck (w_sck_drive),
      .o_sck (w_sck)
   );

   // State register; reset aborts any transfer immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state: slots end on the SCK-high half, END lasts one SCK period
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (trigger) begin
               if (w_n_clamp != 9'd0)           w_state_nxt = ST_SEND;
               else if (data_out_count != 8'd0) w_state_nxt = ST_RECV;
               else                             w_state_nxt = ST_END;
            end
         end
         ST_SEND: begin
            if (w_sck && w_byte_done && w_last_byte)
               w_state_nxt = (r_m != 8'd0) ? ST_RECV : ST_END;
         end
         ST_RECV: begin
            if (w_sck && w_byte_done && w_last_byte) w_state_nxt = ST_END;
         end
         ST_END: begin
            if (r_phase) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: latch the request, step bit/byte counters, shift in responses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_data  <= '0;
         r_quad  <= 1'b0;
         r_m     <= 8'd0;
         r_cnt   <= 9'd0;
         r_bit   <= 3'd7;
         r_phase <= 1'b0;
         r_dout  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_phase <= 1'b0;
               if (trigger) begin
                  r_data <= data_in;
                  r_quad <= quad;
                  r_m    <= data_out_count;
                  r_dout <= '0;
                  r_bit  <= 3'd7;
                  r_cnt  <= (w_n_clamp != 9'd0) ? w_n_clamp : {1'b0, data_out_count};
               end
            end
            ST_SEND, ST_RECV: begin
               r_phase <= ~r_phase;
               if (w_sck) begin
                  if (r_state == ST_RECV)
                     r_dout <= r_quad ? {r_dout[c_DOUT_W-5:0], DQio}
                                      : {r_dout[c_DOUT_W-2:0], DQio[1]};
                  if (w_byte_done) begin
                     r_bit <= 3'd7;
                     // Leaving SEND reloads the counter with the receive length
                     r_cnt <= (w_last_byte && r_state == ST_SEND) ? {1'b0, r_m}
                                                                    : r_cnt - 9'd1;
                  end else begin
                     r_bit <= r_bit - (r_quad ? 3'd4 : 3'd1);
                  end
               end
            end
            ST_END: r_phase <= ~r_phase;
            default: r_phase <= 1'b0;
         endcase
      end
   end

   // DQ drive: MOSI or quad nibble in SEND; single-mode keeps W#/HOLD# high
   always_comb begin
      w_oe = 4'b0000;
      w_dq = 4'b0000;
      if (r_state == ST_SEND) begin
         if (r_quad) begin
            w_oe = 4'b1111;
            w_dq = r_bit[2] ? w_cur_byte[7:4] : w_cur_byte[3:0];
         end else begin
            w_oe = 4'b1101;
            w_dq = {2'b11, 1'b0, w_cur_byte[r_bit]};
         end
      end else if (r_state == ST_RECV && !r_quad) begin
         w_oe = 4'b1101;
         w_dq = 4'b1100;
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_dq
      assign DQio[gi] = w_oe[gi] ? w_dq[gi] : 1'bz;
   end

   assign busy     = (r_state != ST_IDLE);
   assign S        = ~w_active;
   assign data_out = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cmd
// Brief    : Self-checking bench for spi_cmd with a behavioural flash model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cmd;
   import spi_cmd_pkg::*;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                trigger = 1'b0;
   logic                quad = 1'b0;
   logic [8:0]          din_cnt = '0;
   logic [7:0]          dout_cnt = '0;
   logic [c_DIN_W-1:0]  din = '0;
   logic [c_DOUT_W-1:0] dout;
   logic                busy;
   logic                S;
   wire  [3:0]          dq;
   wire                 sck;

   logic [3:0] tb_oe = 4'b0000;
   logic [3:0] tb_val = 4'b0000;

   int n_checks = 0;
   int n_fail = 0;

   // Flash / monitor state
   bit          mon_en = 1'b0;
   bit          cur_q = 1'b0;
   int unsigned send_slots = 0;
   int unsigned slot = 0;
   int unsigned busy_cnt = 0;
   int unsigned s_cnt = 0;
   int unsigned dq_bad = 0;
   int unsigned mon_r;
   logic [7:0]  mon_b;
   logic [3:0]  cap[$];
   logic [7:0]  resp[256];

   logic [7:0] ops[11] = '{c_OP_RDID, c_OP_MIORDID, c_OP_RDSR, c_OP_RFSR, c_OP_WREN,
                           c_OP_PP, c_OP_SE, c_OP_BE, c_OP_READ, c_OP_WRVECR, c_OP_RDVECR};

   spi_cmd dut (
      .clk            (clk),
      .reset          (reset),
      .trigger        (trigger),
      .quad           (quad),
      .data_in_count  (din_cnt),
      .data_out_count (dout_cnt),
      .data_in        (din),
      .data_out       (dout),
      .busy           (busy),
      .DQio           (dq),
      .S              (S)
   );

   assign sck = dut.u_sck_out.sck;

   for (genvar gi = 0; gi < 4; gi++) begin : g_drv
      assign dq[gi] = tb_oe[gi] ? tb_val[gi] : 1'bz;
      pullup (dq[gi]);
   end

   always #5 clk = ~clk;

   always @(posedge S) tb_oe = 4'b0000;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Flash model and bus monitor, sampled on the falling clk edge
   always @(negedge clk) begin
      if (mon_en) begin
         if (busy) busy_cnt++;
         if (S == 1'b0) begin
            s_cnt++;
            if (!cur_q && dq[3:2] !== 2'b11) dq_bad++;
            if (sck == 1'b0) begin
               if (slot >= send_slots) begin
                  mon_r = slot - send_slots;
                  if (cur_q) begin
                     mon_b  = resp[mon_r / 2];
                     tb_oe  = 4'b1111;
                     tb_val = (mon_r % 2 == 0) ? mon_b[7:4] : mon_b[3:0];
                  end else begin
                     mon_b  = resp[mon_r / 8];
                     tb_oe  = 4'b0010;
                     tb_val = {2'b00, mon_b[7 - (mon_r % 8)], 1'b0};
                  end
               end
            end else begin
               if (slot < send_slots) begin
                  cap.push_back(dq);
                  if (!cur_q && dq[1] !== 1'b1) dq_bad++;
               end else if (!cur_q && dq[0] !== 1'b0) begin
                  dq_bad++;
               end
               slot++;
            end
         end else if (dq !== 4'hF) begin
            dq_bad++;
         end
      end
   end

   // One full transaction with reference-model checks on timing, bus and result
   task automatic run_txn(input bit q, input int n, input int m, input bit hold, input string tag);
      int nc, bslots, budget, errs, bi, extra;
      bit done;
      logic [7:0]  b;
      logic [3:0]  e, g;
      logic [63:0] exp_out;
      nc     = (n > c_DIN_BYTES) ? c_DIN_BYTES : n;
      bslots = (q ? 2 : 8) * (nc + m);
      @(negedge clk);
      quad       = q;
      din_cnt    = 9'(n);
      dout_cnt   = 8'(m);
      cur_q      = q;
      send_slots = (q ? 2 : 8) * nc;
      slot = 0; busy_cnt = 0; s_cnt = 0; dq_bad = 0;
      cap.delete();
      mon_en  = 1'b1;
      trigger = 1'b1;
      @(negedge clk);
      if (!hold) trigger = 1'b0;
      budget = c_CLK_PER_SLOT * bslots + 20;
      done = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (!busy) begin
            done = 1'b1;
            break;
         end
      end
      mon_en  = 1'b0;
      trigger = 1'b0;
      chk_eq({tag, ":done"}, 64'(done), 64'd1);
      chk_eq({tag, ":busy_len"}, 64'(busy_cnt), 64'(c_CLK_PER_SLOT * bslots + c_END_CYCLES));
      chk_eq({tag, ":s_len"}, 64'(s_cnt), 64'(c_CLK_PER_SLOT * bslots));
      chk_eq({tag, ":dq_drive"}, 64'(dq_bad), 64'd0);
      exp_out = '0;
      for (int j = 0; j < m; j++) exp_out = {exp_out[55:0], resp[j]};
      chk_eq({tag, ":data_out"}, dout, exp_out);
      chk_eq({tag, ":tx_slots"}, 64'(cap.size()), 64'(send_slots));
      errs = 0;
      for (int k = 0; k < int'(send_slots) && k < cap.size(); k++) begin
         bi = nc - 1 - (q ? k / 2 : k / 8);
         b  = din[bi * 8 +: 8];
         if (q) begin
            e = (k % 2 == 0) ? b[7:4] : b[3:0];
            g = cap[k];
         end else begin
            e = {3'b000, b[7 - (k % 8)]};
            g = {3'b000, cap[k][0]};
         end
         if (g !== e) errs++;
      end
      chk_eq({tag, ":tx_bits"}, 64'(errs), 64'd0);
      if (hold) begin
         extra = 0;
         repeat (6) begin
            @(negedge clk);
            if (busy) extra++;
         end
         chk_eq({tag, ":retrigger"}, 64'(extra), 64'd0);
      end
   endtask

   task automatic fill_random(input int n);
      for (int i = 0; i < c_DIN_BYTES; i++) din[i * 8 +: 8] = 8'($urandom);
      if (n > 0 && n <= c_DIN_BYTES) din[(n - 1) * 8 +: 8] = ops[$urandom_range(0, 10)];
      for (int i = 0; i < 256; i++) resp[i] = 8'($urandom);
   endtask

   initial begin
      logic [63:0] id;
      int rn, rm;
      // Reset state
      #12;
      chk_eq("rst:busy", 64'(busy), 64'd0);
      chk_eq("rst:S", 64'(S), 64'd1);
      chk_eq("rst:data_out", dout, 64'd0);
      chk_eq("rst:dq", 64'(dq), 64'hF);
      chk_eq("rst:sck", 64'(sck), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // Single RDSR, status 0x83
      din = '0; din[7:0] = c_OP_RDSR; resp[0] = 8'h83;
      run_txn(1'b0, 1, 1, 1'b0, "rdsr");
      chk_eq("rdsr:tx_byte", 64'({cap[0][0], cap[1][0], cap[2][0], cap[3][0],
                                  cap[4][0], cap[5][0], cap[6][0], cap[7][0]}), 64'h05);

      // Quad MIORDID returning an 8-byte ID
      din = '0; din[7:0] = c_OP_MIORDID;
      id = 64'h20BA181000112233;
      for (int j = 0; j < 8; j++) resp[j] = id[(7 - j) * 8 +: 8];
      run_txn(1'b1, 1, 8, 1'b0, "miordid");
      chk_eq("miordid:nib0", 64'(cap[0]), 64'hA);
      chk_eq("miordid:nib1", 64'(cap[1]), 64'hF);

      // Long read: 10 bytes, only the last 8 retained
      din = '0; din[31:0] = 32'h03000100;
      for (int j = 0; j < 10; j++) resp[j] = 8'(j + 1);
      run_txn(1'b0, 4, 10, 1'b0, "read10");

      // Write-only WREN after a read left data_out nonzero
      din = '0; din[7:0] = c_OP_WREN;
      run_txn(1'b0, 1, 0, 1'b0, "wren");

      // Empty transaction with trigger held for the whole busy window
      run_txn(1'b0, 0, 0, 1'b1, "empty");

      // Receive-only, count clamp and long quad read
      fill_random(0);   run_txn(1'b0, 0, 3, 1'b0, "rx_only");
      fill_random(260); run_txn(1'b0, 300, 2, 1'b0, "clamp");
      fill_random(5);   run_txn(1'b1, 5, 255, 1'b0, "quad255");

      // Randomized transactions
      for (int t = 0; t < 20; t++) begin
         rn = $urandom_range(0, 12);
         rm = $urandom_range(0, 12);
         fill_random(rn);
         run_txn(1'($urandom_range(0, 1)), rn, rm, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
      end

      // Asynchronous reset in the middle of SEND
      fill_random(6);
      @(negedge clk);
      quad = 1'b0; din_cnt = 9'd6; dout_cnt = 8'd2; trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      repeat (10) @(negedge clk);
      chk_eq("abort:pre_S", 64'(S), 64'd0);
      #2 reset = 1'b0;
      #1;
      chk_eq("abort:busy", 64'(busy), 64'd0);
      chk_eq("abort:S", 64'(S), 64'd1);
      chk_eq("abort:dq", 64'(dq), 64'hF);
      chk_eq("abort:data_out", dout, 64'd0);
      chk_eq("abort:sck", 64'(sck), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      fill_random(3);
      run_txn(1'b1, 3, 2, 1'b0, "post_abort");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
